// File: rtl/dmac_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmac_req_arbiter
// Description : DMA request front end. Samples masked peripheral requests,
//               picks one channel round-robin, pulses its channel_en, waits
//               for the channel's completion irq, then closes a four-phase
//               req/ack handshake with the peripheral. Keeps sticky,
//               write-1-to-clear completion flags per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_req_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic [NUM_CH-1:0] dma_req,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] ch_irq,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic [NUM_CH-1:0] channel_en,
    output logic [NUM_CH-1:0] dma_ack,
    output logic [CH_W-1:0]   grant_id,
    output logic              busy,
    output logic [NUM_CH-1:0] irq_status,
    output logic              irq_out
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_START  = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;
    localparam logic [1:0] c_ACK    = 2'd3;

    localparam logic [NUM_CH-1:0] c_ONE      = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]   c_LAST_RST = CH_W'(NUM_CH - 1);

    logic [1:0]        state_q,      state_d;
    logic [CH_W-1:0]   grant_id_q,   grant_id_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_CH-1:0] channel_en_q, channel_en_d;
    logic [NUM_CH-1:0] dma_ack_q,    dma_ack_d;
    logic              busy_q,       busy_d;
    logic [NUM_CH-1:0] irq_status_q, irq_status_d;

    logic [NUM_CH-1:0] w_eligible;
    logic              w_found;
    logic [CH_W-1:0]   w_next_grant;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [NUM_CH-1:0] w_set_vec;
    int                w_idx;

    // Round-robin search: first eligible channel upward from last_grant+1, wrapping.
    always_comb begin
        w_eligible   = dma_req & ch_mask;
        w_found      = 1'b0;
        w_next_grant = '0;
        w_idx        = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = (int'(last_grant_q) + i) % NUM_CH;
            if (!w_found && w_eligible[w_idx[CH_W-1:0]]) begin
                w_found      = 1'b1;
                w_next_grant = w_idx[CH_W-1:0];
            end
        end
    end

    // Grant FSM plus next-state for all registered outputs.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        channel_en_d = '0;
        dma_ack_d    = dma_ack_q;
        busy_d       = busy_q;
        w_set_vec    = '0;
        w_grant_oh   = c_ONE << grant_id_q;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    grant_id_d   = w_next_grant;
                    channel_en_d = c_ONE << w_next_grant;
                    busy_d       = 1'b1;
                    state_d      = c_START;
                end
            end
            // An irq in START cannot be legitimate yet, so it is not looked at.
            c_START: begin
                state_d = c_ACTIVE;
            end
            // Mask or request changes do not abort a started transfer.
            c_ACTIVE: begin
                if (ch_irq[grant_id_q]) begin
                    w_set_vec = w_grant_oh;
                    dma_ack_d = w_grant_oh;
                    state_d   = c_ACK;
                end
            end
            c_ACK: begin
                if (!dma_req[grant_id_q]) begin
                    dma_ack_d    = '0;
                    last_grant_d = grant_id_q;
                    busy_d       = 1'b0;
                    state_d      = c_IDLE;
                end
            end
            default: begin
                dma_ack_d = '0;
                busy_d    = 1'b0;
                state_d   = c_IDLE;
            end
        endcase
        // Set has priority over a simultaneous clear.
        irq_status_d = (irq_status_q & ~irq_clr) | w_set_vec;
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= c_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= c_LAST_RST;
            channel_en_q <= '0;
            dma_ack_q    <= '0;
            busy_q       <= 1'b0;
            irq_status_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            channel_en_q <= channel_en_d;
            dma_ack_q    <= dma_ack_d;
            busy_q       <= busy_d;
            irq_status_q <= irq_status_d;
        end
    end

    assign channel_en = channel_en_q;
    assign dma_ack    = dma_ack_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign irq_status = irq_status_q;
    assign irq_out    = |irq_status_q;

endmodule
`default_nettype wire

// File: tb/tb_dmac_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmac_req_arbiter
// Description : Self-checking bench for dmac_req_arbiter. Expected grants are
//               queued by the stimulus; a negedge monitor pops one whenever
//               channel_en fires. Handshake/status values checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmac_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dma_req, ch_mask, ch_irq, irq_clr;
    logic [1:0] channel_en, dma_ack, irq_status;
    logic [0:0] grant_id;
    logic       busy, irq_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dmac_req_arbiter #(.NUM_CH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dma_req    (dma_req),
        .ch_mask    (ch_mask),
        .ch_irq     (ch_irq),
        .irq_clr    (irq_clr),
        .channel_en (channel_en),
        .dma_ack    (dma_ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .irq_status (irq_status),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every channel_en pulse must match the next queued grant.
    always @(negedge clk) begin
        if (rst && channel_en != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: channel_en=%b with nothing queued", channel_en);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (channel_en !== (2'b01 << e) || grant_id !== 1'(e)) begin
                    errors++;
                    $display("FAIL grant: channel_en=%b grant_id=%0d expected ch %0d", channel_en, grant_id, e);
                end
            end
        end
    end

    // Bounded wait until the START cycle (channel_en visible).
    task automatic wait_en();
        int n = 0;
        while (channel_en == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_channel_en", 32'(channel_en != 2'b00), 32'd1);
    endtask

    // Full transfer on channel ch, starting from the START cycle.
    task automatic xfer(input int ch, input logic [1:0] drop_val, input logic [1:0] after_val);
        tick();
        tick();
        ch_irq = 2'b01 << ch;
        tick();
        ch_irq = 2'b00;
        chk("xfer_ack", 32'(dma_ack), 32'(2'b01 << ch));
        chk("xfer_gid", 32'(grant_id), 32'(ch));
        dma_req = drop_val;
        tick();
        chk("xfer_ack_low", 32'(dma_ack), 32'd0);
        chk("xfer_idle", 32'(busy), 32'd0);
        dma_req = after_val;
    endtask

    initial begin
        rst = 1'b0; dma_req = 2'b00; ch_mask = 2'b00; ch_irq = 2'b00; irq_clr = 2'b00;

        // 1. Reset values, then first grant.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(channel_en), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_ack", 32'(dma_ack), 32'd0);
        chk("post_rst_status", 32'(irq_status), 32'd0);
        chk("post_rst_irq_out", 32'(irq_out), 32'd0);
        exp_q.push_back(0);
        dma_req = 2'b01; ch_mask = 2'b11;
        tick();
        chk("t1_en", 32'(channel_en), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_en_one_cycle", 32'(channel_en), 32'd0);
        chk("t1_busy_active", 32'(busy), 32'd1);

        // 2. Full handshake: irq 5 cycles after START.
        repeat (3) tick();
        ch_irq = 2'b01;
        tick();
        ch_irq = 2'b00;
        chk("t2_ack", 32'(dma_ack), 32'h1);
        chk("t2_status", 32'(irq_status), 32'h1);
        chk("t2_irq_out", 32'(irq_out), 32'd1);
        repeat (2) tick();
        chk("t2_ack_hold", 32'(dma_ack), 32'h1);
        dma_req = 2'b00;
        tick();
        chk("t2_ack_low", 32'(dma_ack), 32'd0);
        chk("t2_busy_low", 32'(busy), 32'd0);
        tick();
        chk("t2_no_regrant", 32'(channel_en), 32'd0);

        // 3. Round-robin from fresh reset: 0,1,0,1.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        dma_req = 2'b11; ch_mask = 2'b11;
        wait_en(); xfer(0, 2'b10, 2'b11);
        wait_en(); xfer(1, 2'b01, 2'b11);
        wait_en(); xfer(0, 2'b10, 2'b11);
        wait_en(); xfer(1, 2'b00, 2'b00);
        tick();

        // 4. Masking and stray irq.
        irq_clr = 2'b11;
        tick();
        irq_clr = 2'b00;
        chk("t4_cleared", 32'(irq_status), 32'd0);
        dma_req = 2'b10; ch_mask = 2'b01;
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (channel_en != 2'b00) seen++;
            end
            chk("t4_masked", 32'(seen), 32'd0);
        end
        exp_q.push_back(1);
        ch_mask = 2'b11;
        wait_en();
        chk("t4_en", 32'(channel_en), 32'h2);
        tick();
        ch_irq = 2'b01;
        tick();
        ch_irq = 2'b00;
        chk("t4_stray_status", 32'(irq_status), 32'd0);
        chk("t4_stray_ack", 32'(dma_ack), 32'd0);
        chk("t4_stray_busy", 32'(busy), 32'd1);
        ch_irq = 2'b10;
        tick();
        ch_irq = 2'b00;
        chk("t4_ack", 32'(dma_ack), 32'h2);
        chk("t4_status", 32'(irq_status), 32'h2);
        dma_req = 2'b00;
        tick();
        chk("t4_idle", 32'(busy), 32'd0);

        // 5. Clear/set collision on channel 0.
        irq_clr = 2'b11;
        tick();
        irq_clr = 2'b00;
        exp_q.push_back(0);
        dma_req = 2'b01;
        wait_en(); xfer(0, 2'b00, 2'b00);
        chk("t5_status_set", 32'(irq_status), 32'h1);
        exp_q.push_back(0);
        dma_req = 2'b01;
        wait_en();
        tick();
        ch_irq = 2'b01; irq_clr = 2'b01;
        tick();
        ch_irq = 2'b00; irq_clr = 2'b00;
        chk("t5_set_wins", 32'(irq_status), 32'h1);
        dma_req = 2'b00;
        tick();
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        chk("t5_cleared", 32'(irq_status), 32'd0);
        chk("t5_irq_out", 32'(irq_out), 32'd0);

        // 6. Asynchronous reset mid-transfer (last_grant=0, so channel 1 first).
        exp_q.push_back(1);
        dma_req = 2'b11;
        wait_en();
        repeat (3) tick();
        chk("t6_active", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_ack", 32'(dma_ack), 32'd0);
        chk("t6_async_en", 32'(channel_en), 32'd0);
        tick();
        rst = 1'b1;
        exp_q.push_back(0);
        wait_en();
        chk("t6_first_grant", 32'(grant_id), 32'd0);
        xfer(0, 2'b00, 2'b00);
        repeat (2) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
